// File: rtl/char_scroll_buffer.sv
// Character scroll feeder: FIFO-buffered byte stream shifted into a 4-char window at a fixed rate.
// Optional trailing blank-out of the window is enabled by defining SCROLL_FLUSH_EN.
`timescale 1ns/1ps

module char_scroll_buffer #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned SCROLL_DIV = 25000000,
   parameter logic [7:0]  BLANK      = 8'h20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [7:0]               in_char,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [7:0]               char0,
   output logic [7:0]               char1,
   output logic [7:0]               char2,
   output logic [7:0]               char3,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(SCROLL_DIV);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SCROLL_DIV - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   ONE_COUNT  = (AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH
   } state_t;

   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;
   logic [TW-1:0]   timer_q;
   logic [3:0][7:0] win_q;
   state_t          state_q;
`ifdef SCROLL_FLUSH_EN
   logic [1:0]      flush_cnt_q;
`endif

   logic push;
   logic pop;
   logic tick;
   logic empties;

   assign in_ready = (count_q != FULL_COUNT) && !clear && rst_n;
   assign push     = in_valid && in_ready;
   assign tick     = (state_q != S_IDLE) && (timer_q == TIMER_LAST);
   // Only ticks pop, so a char written into an empty FIFO cannot leave in the same cycle.
   assign pop      = tick && (count_q != '0);
   assign empties  = pop && (count_q == ONE_COUNT) && !push;

   always_comb begin
      // NOTE: default assignment first so no path through the block leaves count_d unassigned (no latch).
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + ONE_COUNT;
         2'b01:   count_d = count_q - ONE_COUNT;
         default: count_d = count_q;
      endcase
   end

   // NOTE: the character store has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_char;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         win_q       <= {4{BLANK}};
         state_q     <= S_IDLE;
`ifdef SCROLL_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else if (clear) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         win_q       <= {4{BLANK}};
         state_q     <= S_IDLE;
`ifdef SCROLL_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;

         if (state_q == S_IDLE || tick) timer_q <= '0;
         else                           timer_q <= timer_q + TW'(1);

         case (state_q)
            S_IDLE: begin
               if (count_q != '0) state_q <= S_RUN;
            end
            S_RUN: begin
               if (pop) begin
                  win_q <= {win_q[2:0], mem_q[rd_ptr_q]};
                  if (empties) begin
`ifdef SCROLL_FLUSH_EN
                     state_q     <= S_FLUSH;
                     flush_cnt_q <= '0;
`else
                     state_q     <= S_IDLE;
`endif
                  end
               end
            end
`ifdef SCROLL_FLUSH_EN
            S_FLUSH: begin
               if (pop) begin
                  win_q       <= {win_q[2:0], mem_q[rd_ptr_q]};
                  state_q     <= empties ? S_FLUSH : S_RUN;
                  flush_cnt_q <= '0;
               end else if (tick) begin
                  win_q       <= {win_q[2:0], BLANK};
                  flush_cnt_q <= flush_cnt_q + 2'd1;
                  if (flush_cnt_q == 2'd3) state_q <= S_IDLE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign char0      = win_q[0];
   assign char1      = win_q[1];
   assign char2      = win_q[2];
   assign char3      = win_q[3];
   assign fifo_count = count_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_char_scroll_buffer.sv
// Directed bench for char_scroll_buffer: a fast-scroll instance for timing/flush/clear and a
// slow-scroll instance for FIFO-full back-pressure and asynchronous reset.
`timescale 1ns/1ps

module tb_char_scroll_buffer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_clear, a_valid, a_ready, a_busy;
   logic [7:0] a_char, a_c0, a_c1, a_c2, a_c3;
   logic [4:0] a_count;

   logic       b_clear, b_valid, b_ready, b_busy;
   logic [7:0] b_char, b_c0, b_c1, b_c2, b_c3;
   logic [4:0] b_count;

   char_scroll_buffer #(.DEPTH(16), .SCROLL_DIV(4), .BLANK(8'h20)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_char(a_char), .in_valid(a_valid),
      .in_ready(a_ready), .char0(a_c0), .char1(a_c1), .char2(a_c2), .char3(a_c3),
      .fifo_count(a_count), .busy(a_busy)
   );

   char_scroll_buffer #(.DEPTH(16), .SCROLL_DIV(40), .BLANK(8'h20)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_char(b_char), .in_valid(b_valid),
      .in_ready(b_ready), .char0(b_c0), .char1(b_c1), .char2(b_c2), .char3(b_c3),
      .fifo_count(b_count), .busy(b_busy)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_clear = 0; a_valid = 0; a_char = 8'h00;
      b_clear = 0; b_valid = 0; b_char = 8'h00;

      // Reset held with clock running
      repeat (3) step();
      check("rst_win",   {a_c3, a_c2, a_c1, a_c0}, 32'h20202020);
      check("rst_count", a_count, 0);
      check("rst_busy",  a_busy, 0);
      check("rst_ready", a_ready, 0);
      check("rst_ready_b", b_ready, 0);
      rst_n = 1'b1;
      step();
      check("rel_ready", a_ready, 1);
      check("rel_ready_b", b_ready, 1);

      // "ABCD" back-to-back, accepted at edges N..N+3
      a_valid = 1;
      a_char = 8'h41; step();
      a_char = 8'h42; step();
      a_char = 8'h43; step();
      a_char = 8'h44; step();
      a_valid = 0;
      check("abcd_count_n3", a_count, 4);
      step();                                    // N+4
      check("abcd_win_n4", {a_c3, a_c2, a_c1, a_c0}, 32'h20202020);
      check("abcd_busy_n4", a_busy, 1);
      step();                                    // N+5
      check("abcd_c0_n5", a_c0, 8'h41);
      check("abcd_count_n5", a_count, 3);
      repeat (4) step();                         // N+9
      check("abcd_win_n9", {a_c3, a_c2, a_c1, a_c0}, 32'h20204142);
      repeat (7) step();                         // N+16
      check("abcd_win_n16", {a_c3, a_c2, a_c1, a_c0}, 32'h20414243);
      check("abcd_busy_n16", a_busy, 1);
      step();                                    // N+17
      check("abcd_win_n17", {a_c3, a_c2, a_c1, a_c0}, 32'h41424344);
      check("abcd_busy_n17", a_busy, 0);
      check("abcd_count_n17", a_count, 0);
      repeat (8) step();
      check("abcd_hold", {a_c3, a_c2, a_c1, a_c0}, 32'h41424344);

      // "PQRS" then a push landing on the second tick pop (count 3)
      a_valid = 1;
      a_char = 8'h50; step();                    // M
      a_char = 8'h51; step();
      a_char = 8'h52; step();
      a_char = 8'h53; step();                    // M+3
      a_valid = 0;
      repeat (2) step();                         // M+5
      check("pq_count_m5", a_count, 3);
      check("pq_c0_m5", a_c0, 8'h50);
      repeat (3) step();                         // M+8
      a_valid = 1; a_char = 8'h56;
      step();                                    // M+9: push and pop together
      a_valid = 0;
      check("pp_count", a_count, 3);
      check("pp_busy", a_busy, 1);
      check("pp_win", {a_c3, a_c2, a_c1, a_c0}, 32'h43445051);

      // Clear mid-scroll with in_valid asserted
      repeat (2) step();
      check("pre_clr_count", a_count, 3);
      a_clear = 1; a_valid = 1; a_char = 8'h5A;
      #1;
      check("clr_ready", a_ready, 0);
      step();
      a_clear = 0; a_valid = 0;
      check("clr_win", {a_c3, a_c2, a_c1, a_c0}, 32'h20202020);
      check("clr_count", a_count, 0);
      check("clr_busy", a_busy, 0);
      repeat (20) step();
      check("clr_win_later", {a_c3, a_c2, a_c1, a_c0}, 32'h20202020);
      check("clr_count_later", a_count, 0);

      // "HI", accepted at edges K, K+1
      a_valid = 1;
      a_char = 8'h48; step();
      a_char = 8'h49; step();
      a_valid = 0;
      repeat (8) step();                         // K+9
      check("hi_win_k9", {a_c3, a_c2, a_c1, a_c0}, 32'h20204849);
`ifdef SCROLL_FLUSH_EN
      check("hi_busy_k9", a_busy, 1);
      repeat (4) step();                         // K+13
      check("fl_win_k13", {a_c3, a_c2, a_c1, a_c0}, 32'h20484920);
      repeat (11) step();                        // K+24
      check("fl_win_k24", {a_c3, a_c2, a_c1, a_c0}, 32'h49202020);
      check("fl_busy_k24", a_busy, 1);
      step();                                    // K+25
      check("fl_win_k25", {a_c3, a_c2, a_c1, a_c0}, 32'h20202020);
      check("fl_busy_k25", a_busy, 0);
`else
      check("hi_busy_k9", a_busy, 0);
      repeat (16) step();
      check("hi_hold", {a_c3, a_c2, a_c1, a_c0}, 32'h20204849);
      check("hi_busy_hold", a_busy, 0);
`endif

      // FIFO full: 16 pushes at edges N..N+15, 17th held until after first pop at N+41
      for (int i = 0; i < 16; i++) begin
         b_valid = 1;
         b_char  = 8'h60 + 8'(i);
         #1;
         check($sformatf("fill_ready_%0d", i), b_ready, 1);
         step();
      end
      check("full_count", b_count, 16);
      check("full_ready", b_ready, 0);
      b_char = 8'h70;
      repeat (25) step();                        // N+40
      check("held_count", b_count, 16);
      check("held_ready", b_ready, 0);
      check("held_c0", b_c0, 8'h20);
      step();                                    // N+41: first pop
      check("pop_count", b_count, 15);
      check("pop_ready", b_ready, 1);
      check("pop_c0", b_c0, 8'h60);
      step();                                    // N+42: 17th accepted
      b_valid = 0;
      check("refill_count", b_count, 16);
      check("refill_ready", b_ready, 0);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_c0", b_c0, 8'h20);
      check("arst_count", b_count, 0);
      check("arst_busy", b_busy, 0);
      check("arst_ready", b_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
